// File: rtl/icm_buffer_rsp_dispatch.sv
// icm_buffer_rsp_dispatch: routes ICM get-thread responses to the hit channel or to a DMA miss-fetch request,
// and keeps saturating hit/miss statistics.
module icm_buffer_rsp_dispatch #(
    parameter int COUNT_MAX_LOG       = 2,
    parameter int REQ_TAG_LOG         = 5,
    parameter int PHYSICAL_ADDR_WIDTH = 48,
    parameter int ICM_ADDR_WIDTH      = 64,
    parameter int CACHE_ENTRY_WIDTH   = 256,
    parameter int ICM_SLOT_SIZE       = 8,
    parameter int HEAD_WIDTH          = 2*COUNT_MAX_LOG+REQ_TAG_LOG+PHYSICAL_ADDR_WIDTH+ICM_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           get_rsp_valid,
    input  logic [HEAD_WIDTH:0]            get_rsp_head,
    input  logic [CACHE_ENTRY_WIDTH-1:0]   get_rsp_data,
    output logic                           get_rsp_ready,
    output logic                           hit_rsp_valid,
    output logic [HEAD_WIDTH-1:0]          hit_rsp_head,
    output logic [CACHE_ENTRY_WIDTH-1:0]   hit_rsp_data,
    input  logic                           hit_rsp_ready,
    output logic                           miss_req_valid,
    output logic [HEAD_WIDTH-1:0]          miss_req_head,
    output logic [PHYSICAL_ADDR_WIDTH-1:0] miss_req_addr,
    input  logic                           miss_req_ready,
    input  logic                           stats_clr,
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt
);
    localparam int IAW = ICM_ADDR_WIDTH;
    localparam int PAW = PHYSICAL_ADDR_WIDTH;
    localparam logic [11:0] SLOT_MASK = ~12'(ICM_SLOT_SIZE-1);

    typedef enum logic [1:0] {IDLE, HIT_OUT, MISS_OUT} state_t;
    state_t state, state_nx;

    logic [HEAD_WIDTH-1:0]        head_q;
    logic [CACHE_ENTRY_WIDTH-1:0] data_q;
    logic [PAW-1:0]               addr_q;
    logic accept, hit_done, miss_done, hit_in;
    logic [PAW-1:0] addr_in;

    assign hit_in   = get_rsp_head[HEAD_WIDTH];
    // page base from phy_addr, slot offset within the page from icm_addr; no carry into the page
    assign addr_in  = {get_rsp_head[IAW+PAW-1:IAW+12], get_rsp_head[11:0] & SLOT_MASK};
    assign accept    = get_rsp_valid && get_rsp_ready;
    assign hit_done  = hit_rsp_valid && hit_rsp_ready;
    assign miss_done = miss_req_valid && miss_req_ready;

    assign hit_rsp_head  = head_q;
    assign hit_rsp_data  = data_q;
    assign miss_req_head = head_q;
    assign miss_req_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        get_rsp_ready  = 1'b0;
        hit_rsp_valid  = 1'b0;
        miss_req_valid = 1'b0;
        case (state)
            IDLE: begin
                get_rsp_ready = 1'b1;
                if (get_rsp_valid) state_nx = hit_in ? HIT_OUT : MISS_OUT;
            end
            HIT_OUT: begin
                hit_rsp_valid = 1'b1;
                if (hit_rsp_ready) state_nx = IDLE;
            end
            MISS_OUT: begin
                miss_req_valid = 1'b1;
                if (miss_req_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else if (accept) begin
            head_q <= get_rsp_head[HEAD_WIDTH-1:0];
            data_q <= hit_in ? get_rsp_data : '0;
            addr_q <= hit_in ? '0 : addr_in;
        end else if (hit_done || miss_done) begin
            head_q <= '0;
            data_q <= '0;
            addr_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_done && hit_cnt != '1)   hit_cnt  <= hit_cnt + 32'd1;
            if (miss_done && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_icm_buffer_rsp_dispatch.sv
// tb_icm_buffer_rsp_dispatch: scoreboard bench for the ICM response dispatcher.
module tb_icm_buffer_rsp_dispatch;
    localparam int HW = 121;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           get_rsp_valid = 1'b0;
    logic [HW:0]    get_rsp_head = '0;
    logic [255:0]   get_rsp_data = '0;
    logic           get_rsp_ready;
    logic           hit_rsp_valid;
    logic [HW-1:0]  hit_rsp_head;
    logic [255:0]   hit_rsp_data;
    logic           hit_rsp_ready = 1'b0;
    logic           miss_req_valid;
    logic [HW-1:0]  miss_req_head;
    logic [47:0]    miss_req_addr;
    logic           miss_req_ready = 1'b0;
    logic           stats_clr = 1'b0;
    logic [31:0]    hit_cnt;
    logic [31:0]    miss_cnt;

    icm_buffer_rsp_dispatch dut (
        .clk(clk), .rst(rst),
        .get_rsp_valid(get_rsp_valid), .get_rsp_head(get_rsp_head), .get_rsp_data(get_rsp_data),
        .get_rsp_ready(get_rsp_ready),
        .hit_rsp_valid(hit_rsp_valid), .hit_rsp_head(hit_rsp_head), .hit_rsp_data(hit_rsp_data),
        .hit_rsp_ready(hit_rsp_ready),
        .miss_req_valid(miss_req_valid), .miss_req_head(miss_req_head), .miss_req_addr(miss_req_addr),
        .miss_req_ready(miss_req_ready),
        .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [HW-1:0] head;
        logic [255:0]  data;
        logic [47:0]   addr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [HW:0] mk_head(input logic hit, input logic [4:0] tag,
                                            input logic [47:0] phy, input logic [63:0] icm);
        return {hit, 2'd1, 2'd0, tag, phy, icm};
    endfunction

    // output-side scoreboard and per-cycle invariants
    always @(negedge clk) begin
        if (!rst) begin
            if (hit_rsp_valid || miss_req_valid) chk("excl_valid", {254'd0, hit_rsp_valid, miss_req_valid} & 256'h3, hit_rsp_valid ? 256'h2 : 256'h1);
            if (!hit_rsp_valid) chk("data_zero", hit_rsp_data, 256'd0);
            if ((hit_rsp_valid && hit_rsp_ready) || (miss_req_valid && miss_req_ready)) begin
                if (sb.size() == 0) chk("sb_empty", 256'd0, 256'd1);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_kind", {255'd0, hit_rsp_valid}, {255'd0, e.hit});
                    if (e.hit) begin
                        chk("hit_head", hit_rsp_head, e.head);
                        chk("hit_data", hit_rsp_data, e.data);
                    end else begin
                        chk("miss_head", miss_req_head, e.head);
                        chk("miss_addr", miss_req_addr, e.addr);
                    end
                end
            end
        end
    end

    task automatic send(input logic [HW:0] h, input logic [255:0] d);
        int n = 0;
        exp_t e;
        get_rsp_valid = 1'b1;
        get_rsp_head  = h;
        get_rsp_data  = d;
        do begin @(negedge clk); n++; end while (!get_rsp_ready && n < 50);
        if (!get_rsp_ready) chk("accept_timeout", 256'd0, 256'd1);
        e.hit  = h[HW];
        e.head = h[HW-1:0];
        e.data = h[HW] ? d : 256'd0;
        e.addr = h[HW] ? 48'd0 : {h[111:76], h[11:3], 3'b000};
        sb.push_back(e);
        @(posedge clk); #1;
        get_rsp_valid = 1'b0;
        get_rsp_head  = '0;
        get_rsp_data  = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("drain", 256'(sb.size()), 256'd0);
        @(negedge clk);
    endtask

    logic [HW:0]  h;
    logic [255:0] d;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {255'd0, get_rsp_ready}, 256'd1);
        chk("rst_hit_valid", {255'd0, hit_rsp_valid}, 256'd0);
        chk("rst_miss_valid", {255'd0, miss_req_valid}, 256'd0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 256'd0);
        @(posedge clk); #1;

        // basic hit, ready held high
        hit_rsp_ready = 1'b1; miss_req_ready = 1'b1;
        h = mk_head(1'b1, 5'h0A, 48'h0000_1111_2000, 64'h0000_0000_0000_0120);
        d = {8{32'hDEAD_BEEF}};
        send(h, d);
        @(negedge clk);
        chk("t1_valid", {255'd0, hit_rsp_valid}, 256'd1);
        chk("t1_busy", {255'd0, get_rsp_ready}, 256'd0);
        chk("t1_head", hit_rsp_head, h[HW-1:0]);
        wait_done();
        chk("t1_idle", {255'd0, get_rsp_ready}, 256'd1);
        chk("t1_hit_cnt", hit_cnt, 256'd1);
        chk("t1_miss_cnt", miss_cnt, 256'd0);
        @(posedge clk); #1;

        send(mk_head(1'b0, 5'h03, 48'h0012_3456_5ABC, 64'h3AB), 256'hFFFF);
        @(negedge clk);
        chk("m1_addr", miss_req_addr, 256'h0012_3456_53A8);
        wait_done();
        chk("m1_miss_cnt", miss_cnt, 256'd1);
        @(posedge clk); #1;

        send(mk_head(1'b0, 5'h1F, 48'h0000_0000_7000, 64'hFFF), 256'd0);
        @(negedge clk);
        chk("m2_addr", miss_req_addr, 256'h0000_0000_7FF8);
        wait_done();
        chk("m2_miss_cnt", miss_cnt, 256'd2);
        @(posedge clk); #1;

        // backpressure on the hit channel; miss ready stays high and must be ignored
        hit_rsp_ready = 1'b0;
        h = mk_head(1'b1, 5'h15, 48'hABCD_0000_1000, 64'h1234_5678_9ABC_DEF0);
        d = {4{64'h0123_4567_89AB_CDEF}};
        send(h, d);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {255'd0, hit_rsp_valid}, 256'd1);
            chk("bp_head", hit_rsp_head, h[HW-1:0]);
            chk("bp_data", hit_rsp_data, d);
            chk("bp_ready", {255'd0, get_rsp_ready}, 256'd0);
        end
        chk("bp_hit_cnt_hold", hit_cnt, 256'd1);
        @(posedge clk); #1 hit_rsp_ready = 1'b1;
        wait_done();
        chk("bp_hit_cnt", hit_cnt, 256'd2);
        chk("bp_miss_cnt", miss_cnt, 256'd2);

        // saturation
        force dut.hit_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.hit_cnt;
        send(mk_head(1'b1, 5'h01, 48'h0, 64'h8), 256'h55);
        wait_done();
        chk("sat_hit_cnt", hit_cnt, 256'hFFFF_FFFF);
        @(posedge clk); #1;

        // clear wins over a same-cycle increment
        hit_rsp_ready = 1'b0;
        send(mk_head(1'b1, 5'h02, 48'h0, 64'h10), 256'hAA);
        hit_rsp_ready = 1'b1;
        stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("clr_hit_cnt", hit_cnt, 256'd0);
        chk("clr_miss_cnt", miss_cnt, 256'd0);
        chk("clr_idle", {255'd0, get_rsp_ready}, 256'd1);
        @(posedge clk); #1;

        // asynchronous reset while a miss is stalled
        miss_req_ready = 1'b0;
        send(mk_head(1'b0, 5'h07, 48'h0000_0000_9000, 64'h40), 256'd0);
        @(negedge clk);
        chk("rm_valid_pre", {255'd0, miss_req_valid}, 256'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("rm_valid", {255'd0, miss_req_valid}, 256'd0);
        chk("rm_addr", miss_req_addr, 256'd0);
        chk("rm_cnts", {hit_cnt, miss_cnt}, 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rm_ready", {255'd0, get_rsp_ready}, 256'd1);
        chk("rm_no_replay", {255'd0, miss_req_valid}, 256'd0);
        @(posedge clk); #1;
        miss_req_ready = 1'b1;
        h = mk_head(1'b1, 5'h0C, 48'h0000_2222_3000, 64'h77);
        send(h, 256'hCAFE);
        wait_done();
        chk("rm_hit_cnt", hit_cnt, 256'd1);
        chk("rm_miss_cnt", miss_cnt, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
